aes_key_expander: RTL
=====================

Name: aes_key_expander

Overview:
- Synthesisable, parametrised successor to the file-driven AES-128 key expansion; supports AES-128/192/256 selected per key.
- Accepts one cipher key over a valid/ready handshake and streams the round keys out in order (11/13/15 keys) over a second valid/ready handshake.
- Generates one 32-bit word per cycle using four instances of the existing `sbox` module (`data` 8b in, `dout` 8b out, combinational).
- Sits between the key source and the round pipeline.

Parameters:
- KEY_W, 256, width of the key_in bus; must be 256. Smaller keys are left-justified, so the key occupies key_in[KEY_W-1 -: 32*Nk].
- RK_W, 128, round key width; fixed at 128.
- IDX_W, 4, width of rk_idx.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- key_in  in  KEY_W  cipher key, MSB = first key byte
- key_len  in  2  0=AES-128 (Nk=4, Nr=10), 1=AES-192 (Nk=6, Nr=12), 2=AES-256 (Nk=8, Nr=14), 3=illegal
- key_valid  in  1  key_in/key_len valid
- key_ready  out  1  block can accept a key
- rk_out  out  RK_W  round key, words w[4r]..w[4r+3], w[4r] in MSBs
- rk_idx  out  IDX_W  round index r of rk_out
- rk_valid  out  1  rk_out valid
- rk_ready  in  1  consumer accepts rk_out
- rk_last  out  1  rk_out is round Nr
- busy  out  1  expansion in progress
- err  out  1  one-cycle pulse on acceptance of key_len=3

Behaviour:
- Reset values: key_ready=0 during reset and 1 from the first clock after release; rk_out=0, rk_idx=0, rk_valid=0, rk_last=0, busy=0, err=0. All state is cleared.
- Reset asserted mid-operation aborts the expansion immediately. Partial keys are discarded.
- States:
  - IDLE: key_ready=1.
  - On key_valid&&key_ready with key_len<3, go to EXPAND.
  - With key_len=3: err=1 for the next cycle, stay in IDLE, emit no round keys.
- On acceptance (cycle 0):
  - Load w[0..Nk-1] into an 8-word sliding window.
  - Latch Nk/Nr, set busy=1, key_ready=0.
  - Set word counter i=Nk and rcon=0x01.
- EXPAND: per non-stalled cycle compute w[i] and increment i. With t=w[i-1]:
  - If i mod Nk==0: t = SubWord(RotWord(t)) ^ {rcon,24'h0}, then rcon = xtime(rcon). xtime is a left shift, XOR 0x1B if bit7 was set, giving 01,02,04,...,80,1B,36.
  - Else if Nk==8 and i mod 8==4: t = SubWord(t).
  - w[i] = w[i-Nk] ^ t.
- Output register:
  - Loads round key r once words 4r..4r+3 exist and (!rk_valid || rk_ready).
  - rk_valid rises the cycle after the load condition is met.
  - Round 0 appears at cycle 1.
  - With rk_ready held at 1, subsequent round keys appear every 4 cycles in all modes (AES-256 round 1 appears at cycle 2).
- Handshake:
  - rk_out, rk_idx and rk_last are held stable while rk_valid && !rk_ready.
  - rk_valid drops after acceptance unless the next key loads in the same cycle (back-to-back transfers allowed).
- Stall: word generation pauses while the generated-but-unissued words would exceed one complete round key beyond the output register. There is no overflow and no dropped key.
- Final round key:
  - rk_last=1 with rk_idx=Nr.
  - On its acceptance: busy=0, go to IDLE, key_ready=1 the following cycle.
- key_valid while busy: ignored. key_in changes during expansion: no effect.
- Total words generated: 44/52/60. The word counter saturates at the final word; it never wraps.

Optional Feature:
- Macro: AES_KEY_STORE_EN.
- When defined:
  - Adds a 15x128 round-key store, written as each round key is issued.
  - Adds ports rd_idx in 4 and rd_key out 128.
  - rd_key = store[rd_idx] registered, one-cycle latency.
  - rd_idx>14 returns 0.
  - The store is cleared by rst and retained across IDLE until the next key is accepted.
  - Reads allow round keys to be replayed in reverse for decryption.
- When undefined: no store and no extra ports. Behaviour is otherwise identical.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> 11 keys; rk1=a0fafe1788542cb123a339392a6c7605; rk10=d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1 at cycle 41.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> 13 keys; rk12=e98ba06f448c773c8ecc720401002202, rk_idx=12.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> 15 keys; rk14=fe4890d1e6188d0b046df344706c631e.
- Backpressure: rk_ready random 30% high during the AES-128 run -> same 11 keys in order; rk_out stable while stalled; no duplicates.
- key_len=3 accepted -> err pulses exactly 1 cycle; rk_valid never rises; key_ready=1 again on the following cycle.
- rst asserted mid-expansion of AES-256 -> all outputs return to reset values immediately; the next AES-128 key expands correctly. With AES_KEY_STORE_EN defined, rd_idx=10 after the first test returns d014f9a8c9ee2589e13f0cc8b6630ca6 one cycle later.

Source files
------------

// File: rtl/aes_key_expander_if.sv
// Key-in / round-key-out handshake bundle for aes_key_expander.
// AES_KEY_STORE_EN adds the round-key store read port (rd_idx/rd_key).
interface aes_key_expander_if #(
    parameter int KEY_W = 256,
    parameter int RK_W  = 128,
    parameter int IDX_W = 4
);
    logic [KEY_W-1:0] key_in;
    logic [1:0]       key_len;
    logic             key_valid;
    logic             key_ready;
    logic [RK_W-1:0]  rk_out;
    logic [IDX_W-1:0] rk_idx;
    logic             rk_valid;
    logic             rk_ready;
    logic             rk_last;
    logic             busy;
    logic             err;
`ifdef AES_KEY_STORE_EN
    logic [3:0]       rd_idx;
    logic [RK_W-1:0]  rd_key;

    modport master (
        output key_in, key_len, key_valid, rk_ready, rd_idx,
        input  key_ready, rk_out, rk_idx, rk_valid, rk_last, busy, err, rd_key
    );
    modport slave (
        input  key_in, key_len, key_valid, rk_ready, rd_idx,
        output key_ready, rk_out, rk_idx, rk_valid, rk_last, busy, err, rd_key
    );
`else
    modport master (
        output key_in, key_len, key_valid, rk_ready,
        input  key_ready, rk_out, rk_idx, rk_valid, rk_last, busy, err
    );
    modport slave (
        input  key_in, key_len, key_valid, rk_ready,
        output key_ready, rk_out, rk_idx, rk_valid, rk_last, busy, err
    );
`endif
endinterface

// File: rtl/aes_key_expander.sv
// AES-128/192/256 key expansion, one word per cycle, round keys streamed over valid/ready.
// Optional macro AES_KEY_STORE_EN adds a 15x128 round-key store with a registered read port.

module sbox (
    input  logic [7:0] data,
    output logic [7:0] dout
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] w_inv;

    assign w_inv = gf_inv(data);
    assign dout  = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                 ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

module aes_key_expander #(
    parameter int KEY_W = 256,
    parameter int RK_W  = 128,
    parameter int IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    aes_key_expander_if.slave   bus
);
    typedef enum logic [0:0] {S_IDLE, S_EXPAND} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    state_t           r_state;
    logic             r_key_ready;
    logic             r_busy;
    logic             r_err;
    logic [RK_W-1:0]  r_rk_out;
    logic [IDX_W-1:0] r_rk_idx;
    logic             r_rk_valid;
    logic             r_rk_last;
    logic [31:0]      r_win [0:7];
    logic [5:0]       r_i;
    logic [2:0]       r_kpos;
    logic [2:0]       r_pend;
    logic [3:0]       r_rnd;
    logic [3:0]       r_nk;
    logic [3:0]       r_nr;
    logic [7:0]       r_rcon;

    logic [3:0]       w_nk;
    logic [3:0]       w_nr;
    logic [31:0]      w_kw      [0:7];
    logic [31:0]      w_key_win [0:7];
    logic [5:0]       w_total;
    logic [2:0]       w_old_sel;
    logic [31:0]      w_prev;
    logic [31:0]      w_rot;
    logic [31:0]      w_sub;
    logic [31:0]      w_t;
    logic [31:0]      w_new;
    logic             w_gen;
    logic             w_load;
    logic             w_take;
    logic             w_accept;
    logic [RK_W-1:0]  w_next_rk;

    always_comb begin
        w_nk = 4'd4;
        w_nr = 4'd10;
        case (bus.key_len)
            2'd1:    begin w_nk = 4'd6; w_nr = 4'd12; end
            2'd2:    begin w_nk = 4'd8; w_nr = 4'd14; end
            default: begin w_nk = 4'd4; w_nr = 4'd10; end
        endcase
    end

    // Key words are left-justified; w[0..Nk-1] land at the top of the window.
    always_comb begin
        for (int j = 0; j < 8; j++) begin
            w_kw[j]      = bus.key_in[KEY_W-1-32*j -: 32];
            w_key_win[j] = '0;
        end
        for (int j = 0; j < 8; j++) begin
            if (j >= 8 - int'(w_nk)) w_key_win[j] = w_kw[3'(j + int'(w_nk))];
        end
    end

    assign w_total   = {r_nr + 4'd1, 2'b00};
    assign w_old_sel = 3'(4'd8 - r_nk);
    assign w_prev    = r_win[7];
    assign w_rot     = (r_kpos == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        sbox u_sbox (.data(w_rot[8*g +: 8]), .dout(w_sub[8*g +: 8]));
    end

    always_comb begin
        w_t = w_prev;
        if (r_kpos == 3'd0)
            w_t = w_sub ^ {r_rcon, 24'h000000};
        else if (r_nk == 4'd8 && r_kpos == 3'd4)
            w_t = w_sub;
    end

    assign w_new    = r_win[w_old_sel] ^ w_t;
    assign w_take   = r_rk_valid && bus.rk_ready;
    assign w_accept = (r_state == S_IDLE) && bus.key_valid && r_key_ready;
    // Generation pauses once a full round key is waiting behind the output register.
    assign w_gen    = (r_state == S_EXPAND) && (r_pend < 3'd4) && (r_i < w_total);
    assign w_load   = (r_state == S_EXPAND) && (r_rnd <= r_nr)
                    && ((r_pend == 3'd4) || (r_pend == 3'd3 && w_gen))
                    && (!r_rk_valid || bus.rk_ready);
    assign w_next_rk = (r_pend == 3'd4) ? {r_win[4], r_win[5], r_win[6], r_win[7]}
                                        : {r_win[5], r_win[6], r_win[7], w_new};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_key_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_rk_out    <= '0;
            r_rk_idx    <= '0;
            r_rk_valid  <= 1'b0;
            r_rk_last   <= 1'b0;
            r_i         <= '0;
            r_kpos      <= '0;
            r_pend      <= '0;
            r_rnd       <= '0;
            r_nk        <= '0;
            r_nr        <= '0;
            r_rcon      <= '0;
            for (int j = 0; j < 8; j++) r_win[j] <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_key_ready <= 1'b1;
                    if (w_accept) begin
                        if (bus.key_len == 2'd3) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state     <= S_EXPAND;
                            r_key_ready <= 1'b0;
                            r_busy      <= 1'b1;
                            r_nk        <= w_nk;
                            r_nr        <= w_nr;
                            r_i         <= {2'b00, w_nk};
                            r_kpos      <= 3'd0;
                            r_pend      <= 3'(w_nk - 4'd4);
                            r_rnd       <= 4'd1;
                            r_rcon      <= 8'h01;
                            for (int j = 0; j < 8; j++) r_win[j] <= w_key_win[j];
                            r_rk_out    <= bus.key_in[KEY_W-1 -: RK_W];
                            r_rk_idx    <= '0;
                            r_rk_last   <= 1'b0;
                            r_rk_valid  <= 1'b1;
                        end
                    end
                end
                S_EXPAND: begin
                    if (w_gen) begin
                        for (int j = 0; j < 7; j++) r_win[j] <= r_win[j+1];
                        r_win[7] <= w_new;
                        r_i      <= r_i + 6'd1;
                        r_kpos   <= ({1'b0, r_kpos} == r_nk - 4'd1) ? 3'd0 : r_kpos + 3'd1;
                        if (r_kpos == 3'd0) r_rcon <= xtime(r_rcon);
                    end
                    r_pend <= r_pend + 3'(w_gen) - (w_load ? 3'd4 : 3'd0);
                    if (w_load) begin
                        r_rk_out   <= w_next_rk;
                        r_rk_idx   <= IDX_W'(r_rnd);
                        r_rk_last  <= (r_rnd == r_nr);
                        r_rk_valid <= 1'b1;
                        r_rnd      <= r_rnd + 4'd1;
                    end else if (w_take) begin
                        r_rk_valid <= 1'b0;
                    end
                    if (w_take && r_rk_last) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_key_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.key_ready = r_key_ready;
    assign bus.rk_out    = r_rk_out;
    assign bus.rk_idx    = r_rk_idx;
    assign bus.rk_valid  = r_rk_valid;
    assign bus.rk_last   = r_rk_last;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;

`ifdef AES_KEY_STORE_EN
    logic [RK_W-1:0] r_store [0:14];
    logic [RK_W-1:0] r_rd_key;
    logic            w_st_we;
    logic [3:0]      w_st_idx;
    logic [RK_W-1:0] w_st_data;
    logic            w_accept_ok;

    assign w_accept_ok = w_accept && (bus.key_len != 2'd3);
    assign w_st_we     = w_accept_ok || w_load;
    assign w_st_idx    = w_accept_ok ? 4'd0 : r_rnd;
    assign w_st_data   = w_accept_ok ? bus.key_in[KEY_W-1 -: RK_W] : w_next_rk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < 15; j++) r_store[j] <= '0;
            r_rd_key <= '0;
        end else begin
            if (w_st_we && w_st_idx < 4'd15) r_store[w_st_idx] <= w_st_data;
            r_rd_key <= (bus.rd_idx > 4'd14) ? '0 : r_store[bus.rd_idx];
        end
    end

    assign bus.rd_key = r_rd_key;
`endif
endmodule
